// File: rtl/reg_file_2r1w.sv
// Register file with DEPTH x WIDTH flops, one synchronous write port and two
// independent registered read ports with optional write-to-read forwarding.
module reg_file_2r1w #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wAddr,
    input  logic [WIDTH-1:0]  wData,
    input  logic              re0,
    input  logic [ADDR_W-1:0] rAddr0,
    output logic [WIDTH-1:0]  rData0,
    output logic              rValid0,
    input  logic              re1,
    input  logic [ADDR_W-1:0] rAddr1,
    output logic [WIDTH-1:0]  rData1,
    output logic              rValid1
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] rNext0;
    logic [WIDTH-1:0] rNext1;
    logic             writeOk;

    assign writeOk = we && !((ZERO_REG != 0) && (wAddr == '0));

    // Read-data selection: zero register wins over forwarding, which wins over storage.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rNext0 = regs[rAddr0];
        rNext1 = regs[rAddr1];
        if ((BYPASS != 0) && we && (wAddr == rAddr0)) rNext0 = wData;
        if ((BYPASS != 0) && we && (wAddr == rAddr1)) rNext1 = wData;
        if ((ZERO_REG != 0) && (rAddr0 == '0)) rNext0 = '0;
        if ((ZERO_REG != 0) && (rAddr1 == '0)) rNext1 = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the storage array is cleared by reset, so it must stay in flops, not a RAM macro.
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            rData0  <= '0;
            rData1  <= '0;
            rValid0 <= 1'b0;
            rValid1 <= 1'b0;
        end else begin
            // NOTE: non-blocking updates make same-edge reads see the pre-edge storage contents.
            if (writeOk) regs[wAddr] <= wData;
            rValid0 <= re0;
            rValid1 <= re1;
            if (re0) rData0 <= rNext0;
            if (re1) rData1 <= rNext1;
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Drives a default build and a 16x16 zero-register/no-bypass build from one
// stimulus stream and compares both against a behavioural model every cycle.
module tb_reg_file_2r1w;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [3:0]  wAddr = '0;
    logic [31:0] wData = '0;
    logic        re0 = 1'b0;
    logic [3:0]  rAddr0 = '0;
    logic        re1 = 1'b0;
    logic [3:0]  rAddr1 = '0;

    logic [31:0] rData0A, rData1A;
    logic        rValid0A, rValid1A;
    logic [15:0] rData0B, rData1B;
    logic        rValid0B, rValid1B;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    reg_file_2r1w #(.WIDTH(32), .DEPTH(4), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) dutA (
        .clk(clk), .reset(reset), .we(we), .wAddr(wAddr[1:0]), .wData(wData),
        .re0(re0), .rAddr0(rAddr0[1:0]), .rData0(rData0A), .rValid0(rValid0A),
        .re1(re1), .rAddr1(rAddr1[1:0]), .rData1(rData1A), .rValid1(rValid1A)
    );

    reg_file_2r1w #(.WIDTH(16), .DEPTH(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) dutB (
        .clk(clk), .reset(reset), .we(we), .wAddr(wAddr), .wData(wData[15:0]),
        .re0(re0), .rAddr0(rAddr0), .rData0(rData0B), .rValid0(rValid0B),
        .re1(re1), .rAddr1(rAddr1), .rData1(rData1B), .rValid1(rValid1B)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: storage arrays plus the last value each port delivered.
    logic [31:0] memA [16];
    logic [31:0] memB [16];
    logic [31:0] expD0A, expD1A, expD0B, expD1B;
    logic        expV0A, expV1A, expV0B, expV1B;
    bit          modelOn = 1'b0;

    function automatic logic [31:0] modelRead(input bit zeroReg, input bit bypass, input int ra,
                                              input int wa, input logic w, input logic [31:0] wd,
                                              input logic [31:0] stored);
        if (zeroReg && ra == 0) return 32'h0;
        if (bypass && w && wa == ra) return wd;
        return stored;
    endfunction

    always @(posedge clk) begin
        int waA, ra0A, ra1A, waB, ra0B, ra1B;
        logic [31:0] wdB;
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                memA[i] = 32'h0;
                memB[i] = 32'h0;
            end
            {expD0A, expD1A, expD0B, expD1B} = '0;
            {expV0A, expV1A, expV0B, expV1B} = '0;
            modelOn = 1'b1;
        end else begin
            waA  = int'(wAddr) % 4;
            ra0A = int'(rAddr0) % 4;
            ra1A = int'(rAddr1) % 4;
            waB  = int'(wAddr);
            ra0B = int'(rAddr0);
            ra1B = int'(rAddr1);
            wdB  = wData & 32'h0000_FFFF;
            if (re0) expD0A = modelRead(1'b0, 1'b1, ra0A, waA, we, wData, memA[ra0A]);
            if (re1) expD1A = modelRead(1'b0, 1'b1, ra1A, waA, we, wData, memA[ra1A]);
            if (re0) expD0B = modelRead(1'b1, 1'b0, ra0B, waB, we, wdB, memB[ra0B]);
            if (re1) expD1B = modelRead(1'b1, 1'b0, ra1B, waB, we, wdB, memB[ra1B]);
            expV0A = re0;
            expV1A = re1;
            expV0B = re0;
            expV1B = re1;
            if (we) memA[waA] = wData;
            if (we && waB != 0) memB[waB] = wdB;
        end
    end

    always @(negedge clk) begin
        if (modelOn) begin
            check("model rData0A", rData0A, expD0A);
            check("model rData1A", rData1A, expD1A);
            check("model rValid0A", {31'b0, rValid0A}, {31'b0, expV0A});
            check("model rValid1A", {31'b0, rValid1A}, {31'b0, expV1A});
            check("model rData0B", {16'b0, rData0B}, expD0B);
            check("model rData1B", {16'b0, rData1B}, expD1B);
            check("model rValid0B", {31'b0, rValid0B}, {31'b0, expV0B});
            check("model rValid1B", {31'b0, rValid1B}, {31'b0, expV1B});
        end
    end

    task automatic drive(input logic r, input logic w, input logic [3:0] wa, input logic [31:0] wd,
                         input logic e0, input logic [3:0] a0, input logic e1, input logic [3:0] a1);
        reset  = r;
        we     = w;
        wAddr  = wa;
        wData  = wd;
        re0    = e0;
        rAddr0 = a0;
        re1    = e1;
        rAddr1 = a1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] v;

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        check("reset rData0A", rData0A, 32'h0);
        check("reset rValid0A", {31'b0, rValid0A}, 32'h0);
        check("reset rValid1B", {31'b0, rValid1B}, 32'h0);

        // Load, reset, then read everything back as zero.
        for (int i = 0; i < 4; i++) drive(0, 1, 4'(i), 32'h11 * (i + 1), 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 1, 1, 2);
        check("clear rValid0A on reset", {31'b0, rValid0A}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 4'(i), 1, 4'(i));
            check("clear rData0A", rData0A, 32'h0);
            check("clear rData1A", rData1A, 32'h0);
            check("clear rData0B", {16'b0, rData0B}, 32'h0);
            check("clear rValid0A", {31'b0, rValid0A}, 32'h1);
        end

        // Basic write then read, then hold.
        drive(0, 1, 2, 32'hDEAD_BEEF, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 2, 1, 3);
        check("basic rData0A", rData0A, 32'hDEAD_BEEF);
        check("basic rData1A", rData1A, 32'h0);
        check("basic rData0B", {16'b0, rData0B}, 32'h0000_BEEF);
        check("basic rValid1A", {31'b0, rValid1A}, 32'h1);
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        check("hold rValid0A", {31'b0, rValid0A}, 32'h0);
        check("hold rData0A", rData0A, 32'hDEAD_BEEF);

        // Bypass in build A, old data in build B.
        drive(0, 1, 1, 32'h5, 0, 0, 0, 0);
        drive(0, 1, 1, 32'hA, 1, 1, 0, 0);
        check("bypass on rData0A", rData0A, 32'hA);
        check("bypass off rData0B", {16'b0, rData0B}, 32'h5);
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        check("after bypass rData0A", rData0A, 32'hA);
        check("after bypass rData0B", {16'b0, rData0B}, 32'hA);

        // Zero register in build B only.
        drive(0, 1, 0, 32'hFFFF_FFFF, 1, 0, 1, 0);
        check("zero same-edge rData0B", {16'b0, rData0B}, 32'h0);
        check("no zero reg rData0A", rData0A, 32'hFFFF_FFFF);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        check("zero later rData0B", {16'b0, rData0B}, 32'h0);
        check("no zero reg later rData0A", rData0A, 32'hFFFF_FFFF);

        // Fill with i*0x0101, then back-to-back crossed reads.
        for (int i = 0; i < 16; i++) drive(0, 1, 4'(i), 32'h0101 * i, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0, 1, 4'(i), 1, 4'(15 - i));
            v = (i == 0) ? 32'h0 : 32'h0101 * i;
            check("scaled rData0B", {16'b0, rData0B}, v);
            v = (i == 15) ? 32'h0 : 32'h0101 * (15 - i);
            check("scaled rData1B", {16'b0, rData1B}, v);
            check("scaled rValid0B", {31'b0, rValid0B}, 32'h1);
            check("scaled rValid1B", {31'b0, rValid1B}, 32'h1);
            check("wrapped rData0A", rData0A, 32'h0101 * (12 + i % 4));
        end

        // Reset on the same edge as a write and a read.
        drive(1, 1, 3, 32'h77, 1, 3, 0, 0);
        check("midreset rData0A", rData0A, 32'h0);
        check("midreset rValid0A", {31'b0, rValid0A}, 32'h0);
        drive(0, 0, 0, 0, 1, 3, 1, 3);
        check("midreset read3 A", rData0A, 32'h0);
        check("midreset read3 B", {16'b0, rData1B}, 32'h0);

        // Random traffic with occasional reset, checked by the model process.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 63) == 0), 1'($urandom), 4'($urandom), $urandom,
                  1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
